// File: rtl/sdck_sequencer_if.sv
// Request handshake between a speed-change requester and sdck_sequencer.
// The requester holds i_req_valid and the fields until it sees o_req_ready.
interface sdck_sequencer_if;
    logic       i_req_valid;
    logic [7:0] i_req_ckspd;
    logic       i_req_clk90;
    logic       i_req_shutdown;
    logic       o_req_ready;

    modport master (
        output i_req_valid, i_req_ckspd, i_req_clk90, i_req_shutdown,
        input  o_req_ready
    );

    modport slave (
        input  i_req_valid, i_req_ckspd, i_req_clk90, i_req_shutdown,
        output o_req_ready
    );
endinterface

// File: rtl/sdck_sequencer.sv
// SD clock reconfiguration sequencer: waits for the engine to idle, stops the clock,
// applies new settings and lets them settle. Optional WAIT_IDLE timeout: SDCKSEQ_TIMEOUT_EN.
module sdck_sequencer #(
    parameter int INIT_BEATS     = 80,
    parameter int STOP_CYCLES    = 512,   // must be >= 2
    parameter int SETTLE_BEATS   = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    sdck_sequencer_if.slave     req,
    input  logic                i_busy,
    input  logic                i_ckstb,
    output logic [7:0]          o_cfg_ckspd,
    output logic                o_cfg_clk90,
    output logic                o_cfg_shutdown,
    output logic                o_done,
    output logic                o_err
);
    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(INIT_BEATS, STOP_CYCLES), max2(SETTLE_BEATS, TIMEOUT_CYCLES));
    localparam int CNT_W   = max2(9, $clog2(CNT_MAX + 1));
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t INIT_LAST   = cnt_t'(INIT_BEATS - 1);
    // Shutdown is raised on STOP entry and stays visible through the APPLY cycle,
    // so STOP itself lasts one cycle less than the visible shutdown window.
    localparam cnt_t STOP_LAST   = cnt_t'(STOP_CYCLES - 2);
    localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_BEATS - 1);
`ifdef SDCKSEQ_TIMEOUT_EN
    localparam cnt_t TMO_LAST    = cnt_t'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {INIT, IDLE, WAIT_IDLE, STOP, APPLY, SETTLE} state_e;

    state_e     state_q;
    cnt_t       cnt_q;
    logic [7:0] pend_ckspd_q;
    logic       pend_clk90_q;
    logic       pend_sd_q;
    logic [7:0] ckspd_q;
    logic       clk90_q;
    logic       sd_q;
    logic       ready_q;
    logic       done_q;
`ifdef SDCKSEQ_TIMEOUT_EN
    logic       err_q;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            pend_ckspd_q <= 8'h00;
            pend_clk90_q <= 1'b0;
            pend_sd_q    <= 1'b0;
            ckspd_q      <= 8'hfc;
            clk90_q      <= 1'b0;
            sd_q         <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
`ifdef SDCKSEQ_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef SDCKSEQ_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                INIT: begin
                    if (i_ckstb) begin
                        if (cnt_q == INIT_LAST) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (req.i_req_valid && ready_q) begin
                        pend_ckspd_q <= req.i_req_ckspd;
                        pend_clk90_q <= req.i_req_clk90;
                        pend_sd_q    <= req.i_req_shutdown;
                        ready_q      <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!i_busy) begin
                        sd_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= STOP;
                    end
`ifdef SDCKSEQ_TIMEOUT_EN
                    else if (cnt_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                STOP: begin
                    if (cnt_q == STOP_LAST) state_q <= APPLY;
                    else                    cnt_q   <= cnt_q + 1'b1;
                end
                APPLY: begin
                    ckspd_q <= pend_ckspd_q;
                    clk90_q <= pend_clk90_q;
                    sd_q    <= pend_sd_q;
                    cnt_q   <= '0;
                    // A stopped clock produces no beats, so skip SETTLE.
                    if (pend_sd_q) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (i_ckstb) begin
                        if (cnt_q == SETTLE_LAST) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign req.o_req_ready = ready_q;
    assign o_cfg_ckspd     = ckspd_q;
    assign o_cfg_clk90     = clk90_q;
    assign o_cfg_shutdown  = sd_q;
    assign o_done          = done_q;
`ifdef SDCKSEQ_TIMEOUT_EN
    assign o_err           = err_q;
`else
    assign o_err           = 1'b0;
`endif
endmodule

// File: tb/tb_sdck_sequencer.sv
// Self-checking bench for sdck_sequencer: table-driven and random requests against a
// transaction-level timing model (busy wait, shutdown window, settle beats).
module tb_sdck_sequencer;
    localparam int IB  = 80;
    localparam int S   = 512;
    localparam int SB  = 8;
    localparam int TMO = 16;
`ifdef SDCKSEQ_TIMEOUT_EN
    localparam int BUSY_CAP = 12;
`else
    localparam int BUSY_CAP = 1000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy = 1'b0;
    logic       ckstb = 1'b0;
    logic [7:0] cfg_ckspd;
    logic       cfg_clk90, cfg_sd, done, err;

    int checks = 0;
    int fails  = 0;
    int stb_mode = 0;

    logic [7:0] m_ckspd = 8'hfc;
    logic       m_clk90 = 1'b0;
    logic       m_sd    = 1'b0;

    sdck_sequencer_if rif ();

    sdck_sequencer #(
        .INIT_BEATS(IB), .STOP_CYCLES(S), .SETTLE_BEATS(SB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .req(rif.slave), .i_busy(busy), .i_ckstb(ckstb),
        .o_cfg_ckspd(cfg_ckspd), .o_cfg_clk90(cfg_clk90), .o_cfg_shutdown(cfg_sd),
        .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    // Beat strobe changes #2 after the edge, so a read at #1 sees the value just sampled.
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (stb_mode)
                0:       ckstb = (cyc % 4 == 0);
                1:       ckstb = ($urandom_range(2) == 0);
                default: ckstb = 1'b1;
            endcase
        end
    end

    typedef struct {
        logic [7:0] ckspd;
        logic       clk90;
        logic       sd;
        int         nbusy;
        int         mode;
        logic [7:0] e_ckspd;
        logic       e_clk90;
        logic       e_sd;
    } vec_t;

    function automatic logic [12:0] obs();
        return {cfg_ckspd, cfg_clk90, cfg_sd, rif.o_req_ready, done, err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_fields();
        rif.i_req_ckspd    = 8'($urandom);
        rif.i_req_clk90    = 1'($urandom);
        rif.i_req_shutdown = 1'($urandom);
    endtask

    // Called #1 after an edge. Holds reset, then counts beats until ready must rise.
    task automatic do_reset_init(input int hold);
        int  cnt = 0;
        bit  seen = 0;
        bit  er;
        rst_n = 1'b0;
        rif.i_req_valid = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("reset_state", obs(), {8'hfc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        m_ckspd = 8'hfc; m_clk90 = 1'b0; m_sd = 1'b0;
        rst_n = 1'b1;
        rif.i_req_valid = 1'b1;
        rand_fields();
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk); #1;
            if (ckstb) cnt++;
            er = (cnt >= IB);
            chk("init_seq", obs(), {m_ckspd, m_clk90, m_sd, er, 1'b0, 1'b0});
            if (er) seen = 1;
            else    rand_fields();
        end
        chk("init_ready_seen", 32'(seen), 32'd1);
        rif.i_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("init_idle_hold", obs(), {m_ckspd, m_clk90, m_sd, 1'b1, 1'b0, 1'b0});
    endtask

    // Handshake k=0 edge; busy low first sampled at k=kw; shutdown window kw..ka-1; apply at ka.
    task automatic run_req(input logic [7:0] ck, input logic c90, input logic sd,
                           input int nb_in, input int abort_k);
        int nb, kw, ka, cnt, dk;
        bit ok, fin, aborted;
        logic ed;
        nb = (nb_in > BUSY_CAP) ? BUSY_CAP : nb_in;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rif.o_req_ready) ok = 1;
            else begin @(posedge clk); #1; end
        end
        chk("req_ready_wait", 32'(ok), 32'd1);
        rif.i_req_valid    = 1'b1;
        rif.i_req_ckspd    = ck;
        rif.i_req_clk90    = c90;
        rif.i_req_shutdown = sd;
        busy = (nb > 0);
        kw = nb + 1;
        ka = kw + S;
        cnt = 0; dk = -1; fin = 0; aborted = 0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            logic [7:0] e_ck;
            logic       e_c90, e_sd;
            @(posedge clk); #1;
            if (!sd && k > ka && ckstb && cnt < SB) begin
                cnt++;
                if (cnt == SB) dk = k;
            end
            if (sd && k == ka) dk = k;
            e_ck  = (k >= ka) ? ck  : m_ckspd;
            e_c90 = (k >= ka) ? c90 : m_clk90;
            e_sd  = (k >= kw && k < ka) ? 1'b1 : ((k >= ka) ? sd : m_sd);
            ed    = (k == dk);
            chk("seq", obs(), {e_ck, e_c90, e_sd, ed, ed, 1'b0});
            if (ed) fin = 1;
            if (abort_k > 0 && k == abort_k) begin aborted = 1; fin = 1; end
            rif.i_req_valid = (k < nb + 10) ? 1'($urandom) : 1'b0;
            rand_fields();
            busy = (k + 1 <= nb) ? 1'b1 : ((k + 1 > kw) ? 1'($urandom) : 1'b0);
        end
        chk("seq_finished", 32'(fin), 32'd1);
        rif.i_req_valid = 1'b0;
        busy = 1'b0;
        if (aborted) begin
            do_reset_init(1);
        end else begin
            m_ckspd = ck; m_clk90 = c90; m_sd = sd;
            @(posedge clk); #1;
            chk("post_done_idle", obs(), {m_ckspd, m_clk90, m_sd, 1'b1, 1'b0, 1'b0});
        end
    endtask

`ifdef SDCKSEQ_TIMEOUT_EN
    task automatic run_tmo();
        bit fin = 0;
        logic e;
        @(posedge clk); #1;
        rif.i_req_valid = 1'b1;
        rand_fields();
        busy = 1'b1;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(posedge clk); #1;
            rif.i_req_valid = 1'b0;
            e = (k == TMO);
            chk("tmo_seq", obs(), {m_ckspd, m_clk90, m_sd, e, 1'b0, e});
            if (e) fin = 1;
        end
        chk("tmo_seen", 32'(fin), 32'd1);
        busy = 1'b0;
        @(posedge clk); #1;
        chk("tmo_idle", obs(), {m_ckspd, m_clk90, m_sd, 1'b1, 1'b0, 1'b0});
    endtask
`endif

    initial begin
        vec_t tbl [6];
        tbl[0] = '{8'h03, 1'b1, 1'b0, 0,   0, 8'h03, 1'b1, 1'b0};
        tbl[1] = '{8'h5a, 1'b0, 1'b0, 100, 1, 8'h5a, 1'b0, 1'b0};
        tbl[2] = '{8'h5a, 1'b0, 1'b0, 0,   2, 8'h5a, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 1'b1, 3,   2, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{8'h81, 1'b1, 1'b0, 7,   1, 8'h81, 1'b1, 1'b0};
        tbl[5] = '{8'hc3, 1'b0, 1'b0, 1,   0, 8'hc3, 1'b0, 1'b0};

        rif.i_req_valid = 1'b0;
        rand_fields();
        @(posedge clk); #1;
        stb_mode = 0;
        do_reset_init(3);

        for (int i = 0; i < 6; i++) begin
            stb_mode = tbl[i].mode;
            run_req(tbl[i].ckspd, tbl[i].clk90, tbl[i].sd, tbl[i].nbusy, 0);
            chk("tbl_cfg", {cfg_ckspd, cfg_clk90, cfg_sd},
                {tbl[i].e_ckspd, tbl[i].e_clk90, tbl[i].e_sd});
        end

        for (int i = 0; i < 6; i++) begin
            stb_mode = $urandom_range(2);
            run_req(8'($urandom), 1'($urandom), ($urandom_range(3) == 0),
                    $urandom_range(40), 0);
        end

        // Reset in the middle of STOP, then a normal request after re-init.
        stb_mode = 0;
        run_req(8'h22, 1'b1, 1'b0, 5, 5 + 1 + 20);
        run_req(8'h44, 1'b0, 1'b0, 2, 0);
        chk("after_abort_cfg", {cfg_ckspd, cfg_clk90, cfg_sd}, {8'h44, 1'b0, 1'b0});

`ifdef SDCKSEQ_TIMEOUT_EN
        run_tmo();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/sdck_sequencer.md
SDCK_SEQUENCER -- requirements
Module: sdck_sequencer

Interface
REQ-001 SHALL provide parameter INIT_BEATS, default 80, SD clock beats (i_ckstb pulses) required after reset before first request is accepted.
REQ-002 SHALL provide parameter STOP_CYCLES, default 512, system clocks shutdown is held before new settings are applied.
REQ-003 SHALL provide parameter SETTLE_BEATS, default 8, i_ckstb pulses counted after apply before completion.
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 65536, maximum system clocks spent waiting for i_busy low (used only under REQ-024).
REQ-005 Ports: i_clk  input  1  system clock; all logic on rising edge.
REQ-006 Ports: i_reset_n  input  1  reset, synchronous, active-low.
REQ-007 Ports: i_req_valid  input  1  speed-change request; i_req_ckspd  input  8  divider code; i_req_clk90  input  1  90-degree mode; i_req_shutdown  input  1  stop clock.
REQ-008 Ports: o_req_ready  output  1  request accepted when valid && ready.
REQ-009 Ports: i_busy  input  1  command/data engine active; i_ckstb  input  1  clock-beat strobe from clock generator.
REQ-010 Ports: o_cfg_ckspd  output  8, o_cfg_clk90  output  1, o_cfg_shutdown  output  1  registered configuration to clock generator.
REQ-011 Ports: o_done  output  1  one-cycle completion pulse; o_err  output  1  one-cycle timeout pulse.

Function
REQ-012 States SHALL be INIT, IDLE, WAIT_IDLE, STOP, APPLY, SETTLE.
REQ-013 INIT: count i_ckstb pulses; at INIT_BEATS-th pulse go IDLE next cycle; o_req_ready=0.
REQ-014 o_req_ready SHALL be 1 only in IDLE; accepted request fields SHALL be latched into a pending register on the handshake cycle; IDLE->WAIT_IDLE.
REQ-015 WAIT_IDLE: when i_busy=0 go STOP; o_cfg_* unchanged.
REQ-016 STOP: o_cfg_shutdown=1 for exactly STOP_CYCLES clocks, then APPLY.
REQ-017 APPLY (1 cycle): o_cfg_ckspd/o_cfg_clk90 <= pending; o_cfg_shutdown <= pending shutdown; if pending shutdown=1 go IDLE with o_done=1 next cycle, else SETTLE.
REQ-018 SETTLE: count SETTLE_BEATS i_ckstb pulses (counter cleared on entry), then IDLE with one-cycle o_done.
REQ-019 o_cfg_* SHALL change only in STOP (shutdown) and APPLY; i_req_* changes outside the handshake SHALL have no effect.
REQ-020 i_req_valid while not ready SHALL be ignored (not queued); requester holds valid.
REQ-021 Request identical to current settings SHALL still run full sequence.
REQ-022 i_ckstb in same cycle as state entry SHALL count only if the state counts beats (INIT/SETTLE) and was entered that cycle's previous edge; counters 9-bit min, saturating never, sized from parameters.

Reset
REQ-023 On i_reset_n=0 at a clock edge: state INIT, counters 0, o_cfg_ckspd=8'hfc, o_cfg_clk90=0, o_cfg_shutdown=0, o_req_ready=0, o_done=0, o_err=0; reset mid-sequence SHALL abandon pending request.

Configuration
REQ-024 Macro SDCKSEQ_TIMEOUT_EN defined: WAIT_IDLE counts clocks; reaching TIMEOUT_CYCLES with i_busy=1 SHALL drop pending request, pulse o_err one cycle, return IDLE, o_cfg_* unchanged.
REQ-025 Macro undefined: no timeout counter; WAIT_IDLE waits indefinitely; o_err tied 0.

Verification
REQ-026 Reset, i_ckstb every 4 clocks -> o_req_ready rises after 80th pulse, o_cfg_ckspd=8'hfc, clk90=0, shutdown=0.
REQ-027 Request ckspd=8'h03, clk90=1, busy=0 -> shutdown=1 for 512 clocks, then ckspd=8'h03, clk90=1, shutdown=0, o_done after 8 ckstb pulses.
REQ-028 Request with i_busy=1 for 100 clocks -> shutdown stays 0 until busy falls, then sequence per REQ-027.
REQ-029 Request shutdown=1 -> shutdown=1 after apply, o_done one cycle after APPLY, no SETTLE; ckstb ignored.
REQ-030 Reset asserted during STOP -> next cycle shutdown=0, ckspd=8'hfc, o_req_ready=0, INIT restarts.
REQ-031 With SDCKSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, busy held 1 -> o_err pulse at clock 16 of WAIT_IDLE, o_req_ready=1 next, cfg unchanged.
